// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared types and constants for the falling-block piano game
//               controller: FSM state codes, BCD score ceiling and the
//               widths of the slow and lives fields.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_OVER      = 3'd4
  } state_t;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  localparam int SLOW_W  = 3;
  localparam int LIVES_W = 3;

  typedef logic [SLOW_W-1:0]  slow_t;
  typedef logic [LIVES_W-1:0] lives_t;

endpackage
`default_nettype wire

// File: rtl/bcd_inc4.sv
`default_nettype none
// ============================================================================
// Module      : bcd_inc4
// Description : Combinational saturating 4-digit BCD incrementer. Adds one
//               to a packed four-digit BCD value; 9999 passes through
//               unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_inc4
  import game_pkg::*;
(
  input  logic [15:0] in,
  output logic [15:0] out
);

  logic w_carry;

  // Ripple a +1 carry from the least significant digit, wrapping 9 to 0.
  always_comb begin
    out     = in;
    w_carry = 1'b1;
    if (in != BCD_MAX) begin
      for (int d = 0; d < 4; d++) begin
        if (w_carry) begin
          if (in[d*4 +: 4] == 4'd9) begin
            out[d*4 +: 4] = 4'd0;
          end else begin
            out[d*4 +: 4] = in[d*4 +: 4] + 4'd1;
            w_carry       = 1'b0;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer
// Description : Round controller for the falling-block piano game. Steps
//               IDLE -> COUNTDOWN -> PLAY -> OVER, drives the block mover
//               (enable, reset, speed, pattern seed) and keeps the BCD
//               score, remaining lives and difficulty level.
//               Build option GAME_PAUSE_EN adds a PAUSE state toggled by
//               btn_pause; without it btn_pause is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer
  import game_pkg::*;
#(
  parameter int LIVES_INIT = 3,
  parameter int LEVEL_STEP = 10,
  parameter int SLOW_INIT  = 4,
  parameter int SLOW_MIN   = 1,
  parameter int CD_TICKS   = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        hit,
  input  logic        miss,
  output logic        mover_ena,
  output logic        mover_rst,
  output logic [2:0]  slow,
  output logic [3:0]  seed,
  output logic [15:0] score,
  output logic [2:0]  lives,
  output logic [2:0]  state,
  output logic        game_over
);

  localparam int             CD_W         = (CD_TICKS > 1) ? $clog2(CD_TICKS) : 1;
  localparam logic [CD_W-1:0] C_CD_LAST    = CD_W'(CD_TICKS - 1);
  localparam logic [7:0]      C_LEVEL_LAST = 8'(LEVEL_STEP - 1);
  localparam lives_t          C_LIVES_INIT = lives_t'(LIVES_INIT);
  localparam slow_t           C_SLOW_INIT  = slow_t'(SLOW_INIT);
  localparam slow_t           C_SLOW_MIN   = slow_t'(SLOW_MIN);

  state_t          r_state;
  logic            r_mover_ena;
  logic            r_mover_rst;
  slow_t           r_slow;
  logic [3:0]      r_seed;
  logic [15:0]     r_score;
  lives_t          r_lives;
  logic            r_game_over;
  logic [3:0]      r_free;
  logic [CD_W-1:0] r_cd_cnt;
  logic [7:0]      r_hit_cnt;
  logic            r_hit_d1;
  logic            r_hit_d2;
  logic            r_miss_d1;
  logic            r_miss_d2;

  logic        w_start;
  logic        w_hit_rise;
  logic        w_miss_rise;
  logic        w_last_life;
  logic [15:0] w_score_inc;

  // A start press restarts from any state except an already running countdown.
  assign w_start     = btn_start && (r_state != ST_COUNTDOWN);
  assign w_hit_rise  = r_hit_d1 & ~r_hit_d2;
  assign w_miss_rise = r_miss_d1 & ~r_miss_d2;
  assign w_last_life = (r_lives <= lives_t'(1));

`ifndef GAME_PAUSE_EN
  logic w_unused_pause;
  assign w_unused_pause = btn_pause;
`endif

  bcd_inc4 u_bcd_inc4 (
    .in  (w_score_inc_src()),
    .out (w_score_inc)
  );

  function automatic logic [15:0] w_score_inc_src();
    return r_score;
  endfunction

  // Free-running seed source, advancing every clock since reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_free <= 4'd0;
    else     r_free <= r_free + 4'd1;
  end

  // Two-stage edge detectors; a new game preloads them as "already high" so a
  // flag still asserted from the last round does not register as a new edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_d1  <= 1'b0;
      r_hit_d2  <= 1'b0;
      r_miss_d1 <= 1'b0;
      r_miss_d2 <= 1'b0;
    end else if (w_start) begin
      r_hit_d1  <= 1'b1;
      r_hit_d2  <= 1'b1;
      r_miss_d1 <= 1'b1;
      r_miss_d2 <= 1'b1;
    end else begin
      r_hit_d1  <= hit;
      r_hit_d2  <= r_hit_d1;
      r_miss_d1 <= miss;
      r_miss_d2 <= r_miss_d1;
    end
  end

  // Round FSM with registered mover controls, score, lives and level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mover_ena <= 1'b0;
      r_mover_rst <= 1'b1;
      r_slow      <= C_SLOW_INIT;
      r_seed      <= 4'd0;
      r_score     <= 16'h0000;
      r_lives     <= C_LIVES_INIT;
      r_game_over <= 1'b0;
      r_cd_cnt    <= '0;
      r_hit_cnt   <= 8'd0;
    end else begin
      r_mover_rst <= 1'b0;
      if (w_start) begin
        r_state     <= ST_COUNTDOWN;
        r_mover_rst <= 1'b1;
        r_mover_ena <= 1'b0;
        r_game_over <= 1'b0;
        r_score     <= 16'h0000;
        r_hit_cnt   <= 8'd0;
        r_lives     <= C_LIVES_INIT;
        r_slow      <= C_SLOW_INIT;
        r_seed      <= r_free;
        r_cd_cnt    <= '0;
      end else begin
        case (r_state)
          ST_COUNTDOWN: begin
            if (r_cd_cnt == C_CD_LAST) begin
              r_state     <= ST_PLAY;
              r_mover_ena <= 1'b1;
              r_cd_cnt    <= '0;
            end else begin
              r_cd_cnt <= r_cd_cnt + 1'b1;
            end
          end
          ST_PLAY: begin
            // A miss takes precedence over a simultaneous hit.
            if (w_miss_rise) begin
              if (w_last_life) begin
                r_lives     <= lives_t'(0);
                r_state     <= ST_OVER;
                r_mover_ena <= 1'b0;
                r_game_over <= 1'b1;
              end else begin
                r_lives <= r_lives - lives_t'(1);
              end
            end else if (w_hit_rise) begin
              r_score <= w_score_inc;
              if (r_hit_cnt == C_LEVEL_LAST) begin
                r_hit_cnt <= 8'd0;
                if (r_slow > C_SLOW_MIN) r_slow <= r_slow - slow_t'(1);
              end else begin
                r_hit_cnt <= r_hit_cnt + 8'd1;
              end
            end
`ifdef GAME_PAUSE_EN
            // Pausing yields to a game-ending miss on the same cycle.
            if (btn_pause && !(w_miss_rise && w_last_life)) begin
              r_state     <= ST_PAUSE;
              r_mover_ena <= 1'b0;
            end
`endif
          end
`ifdef GAME_PAUSE_EN
          ST_PAUSE: begin
            if (btn_pause) begin
              r_state     <= ST_PLAY;
              r_mover_ena <= 1'b1;
            end
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

  assign mover_ena = r_mover_ena;
  assign mover_rst = r_mover_rst;
  assign slow      = r_slow;
  assign seed      = r_seed;
  assign score     = r_score;
  assign lives     = r_lives;
  assign state     = r_state;
  assign game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_sequencer
// Description : Directed self-checking bench for game_sequencer with
//               CD_TICKS=8 and LEVEL_STEP=3. Expected values are queued when
//               stimulus is applied and popped when the outputs are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

  logic        clk;
  logic        rst;
  logic        btn_start;
  logic        btn_pause;
  logic        hit;
  logic        miss;
  logic        mover_ena;
  logic        mover_rst;
  logic [2:0]  slow;
  logic [3:0]  seed;
  logic [15:0] score;
  logic [2:0]  lives;
  logic [2:0]  state;
  logic        game_over;

  int n_tests;
  int n_fail;

  logic [3:0] tb_free;
  logic [3:0] exp_seed;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];

  game_sequencer #(
    .LIVES_INIT (3),
    .LEVEL_STEP (3),
    .SLOW_INIT  (4),
    .SLOW_MIN   (1),
    .CD_TICKS   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_pause (btn_pause),
    .hit       (hit),
    .miss      (miss),
    .mover_ena (mover_ena),
    .mover_rst (mover_rst),
    .slow      (slow),
    .seed      (seed),
    .score     (score),
    .lives     (lives),
    .state     (state),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference free-running counter: counts clocks since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_free <= 4'd0;
    else     tb_free <= tb_free + 4'd1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string tag, input logic [15:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [15:0] obs);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h required none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic press_start();
    exp_seed  = tb_free;
    btn_start = 1'b1;
    tick(1);
    btn_start = 1'b0;
  endtask

  task automatic press_pause();
    btn_pause = 1'b1;
    tick(1);
    btn_pause = 1'b0;
  endtask

  task automatic hit_held(input int n);
    repeat (n) begin
      hit = 1'b1;
      tick(5);
      hit = 1'b0;
      tick(3);
    end
  endtask

  task automatic hit_short(input int n);
    repeat (n) begin
      hit = 1'b1;
      tick(1);
      hit = 1'b0;
      tick(1);
    end
    tick(2);
  endtask

  task automatic miss_pulse();
    miss = 1'b1;
    tick(2);
    miss = 1'b0;
    tick(3);
  endtask

  initial begin
    int cur_score;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    btn_start = 1'b0;
    btn_pause = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;
    tick(2);

    // Reset values
    push("rst_state", 16'h0000); pop_check(16'(state));
    push("rst_lives", 16'h0003); pop_check(16'(lives));
    push("rst_slow",  16'h0004); pop_check(16'(slow));
    push("rst_score", 16'h0000); pop_check(score);
    push("rst_ena",   16'h0000); pop_check(16'(mover_ena));
    push("rst_mrst",  16'h0001); pop_check(16'(mover_rst));
    push("rst_over",  16'h0000); pop_check(16'(game_over));

    rst = 1'b0;
    tick(5);

    // First game: countdown of 8 cycles with a single mover reset cycle
    press_start();
    push("cd_state0", 16'h0001); pop_check(16'(state));
    push("cd_mrst0",  16'h0001); pop_check(16'(mover_rst));
    push("cd_seed",   16'(exp_seed)); pop_check(16'(seed));
    tick(1);
    push("cd_state1", 16'h0001); pop_check(16'(state));
    push("cd_mrst1",  16'h0000); pop_check(16'(mover_rst));
    tick(6);
    push("cd_state7", 16'h0001); pop_check(16'(state));
    push("cd_ena7",   16'h0000); pop_check(16'(mover_ena));
    tick(1);
    push("play_state", 16'h0002); pop_check(16'(state));
    push("play_ena",   16'h0001); pop_check(16'(mover_ena));

    // Held hits count once each; level steps every 3 hits down to the floor
    push("hit3_score", 16'h0003); push("hit3_slow", 16'h0003);
    hit_held(3);
    pop_check(score); pop_check(16'(slow));
    push("hit12_score", 16'h0012); push("hit12_slow", 16'h0001);
    hit_held(9);
    pop_check(score); pop_check(16'(slow));
    push("hit15_score", 16'h0015); push("hit15_slow", 16'h0001);
    hit_held(3);
    pop_check(score); pop_check(16'(slow));

    // Lose all lives
    push("miss1_lives", 16'h0002); miss_pulse(); pop_check(16'(lives));
    push("miss2_lives", 16'h0001); miss_pulse(); pop_check(16'(lives));
    push("miss3_lives", 16'h0000); push("over_state", 16'h0004);
    push("over_flag", 16'h0001);   push("over_ena", 16'h0000);
    miss_pulse();
    pop_check(16'(lives)); pop_check(16'(state));
    pop_check(16'(game_over)); pop_check(16'(mover_ena));
    push("over_hit_score", 16'h0015);
    hit_held(1);
    pop_check(score);

    // Restart from OVER
    tick(3);
    press_start();
    push("rs_state", 16'h0001); pop_check(16'(state));
    push("rs_score", 16'h0000); pop_check(score);
    push("rs_lives", 16'h0003); pop_check(16'(lives));
    push("rs_slow",  16'h0004); pop_check(16'(slow));
    push("rs_seed",  16'(exp_seed)); pop_check(16'(seed));
    push("rs_gover", 16'h0000); pop_check(16'(game_over));
    tick(9);
    push("rs_play", 16'h0002); pop_check(16'(state));

    // Pause behaviour
    press_pause();
`ifdef GAME_PAUSE_EN
    push("pause_state", 16'h0003); pop_check(16'(state));
    push("pause_ena",   16'h0000); pop_check(16'(mover_ena));
    push("pause_hit",   16'h0000); hit_held(1); pop_check(score);
    press_pause();
    tick(1);
    push("resume_state", 16'h0002); pop_check(16'(state));
    push("resume_ena",   16'h0001); pop_check(16'(mover_ena));
    cur_score = 0;
`else
    push("nopause_state", 16'h0002); pop_check(16'(state));
    push("nopause_ena",   16'h0001); pop_check(16'(mover_ena));
    push("nopause_hit",   16'h0001); hit_held(1); pop_check(score);
    cur_score = 1;
`endif

    // Climb to 9998 then exercise the saturation boundary
    push("pre_score", 16'h9998);
    hit_short(9998 - cur_score);
    pop_check(score);
    push("both_lives", 16'h0002); push("both_score", 16'h9998);
    hit  = 1'b1;
    miss = 1'b1;
    tick(2);
    hit  = 1'b0;
    miss = 1'b0;
    tick(3);
    pop_check(16'(lives)); pop_check(score);
    push("sat1_score", 16'h9999); hit_held(1); pop_check(score);
    push("sat2_score", 16'h9999); hit_held(1); pop_check(score);

    // Restart straight from PLAY
    press_start();
    push("prs_state", 16'h0001); pop_check(16'(state));
    push("prs_score", 16'h0000); pop_check(score);
    push("prs_lives", 16'h0003); pop_check(16'(lives));
    push("prs_ena",   16'h0000); pop_check(16'(mover_ena));
    tick(10);
    push("prs_play", 16'h0002); pop_check(16'(state));
    push("prs_hit",  16'h0001); hit_held(1); pop_check(score);

    // Asynchronous reset in the middle of PLAY
    #2;
    rst = 1'b1;
    #1;
    push("arst_state", 16'h0000); pop_check(16'(state));
    push("arst_score", 16'h0000); pop_check(score);
    push("arst_lives", 16'h0003); pop_check(16'(lives));
    push("arst_slow",  16'h0004); pop_check(16'(slow));
    push("arst_ena",   16'h0000); pop_check(16'(mover_ena));
    push("arst_mrst",  16'h0001); pop_check(16'(mover_rst));
    push("arst_seed",  16'h0000); pop_check(16'(seed));
    tick(2);
    rst = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
